screen_sequencer: RTL and testbench

- Control stage directly upstream of frame_writer; drives frame_writer's 4-bit screen select input.
- Consumes the one-cycle press pulses from the key edge detectors, plus the slide switches.
- Provides manual stepping (next/prev), an auto-advance slideshow mode with a programmable dwell time, and a switch-override mode that selects the screen directly from SW.

---
 rtl/screen_pkg.sv | 37 +++
 rtl/dwell_timer.sv | 34 +++
 rtl/screen_sequencer.sv | 93 +++++++++
 tb/tb_screen_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/screen_pkg.sv
// Shared types and helpers for the screen sequencer: state encoding, screen
// index width and the wrap/clamp arithmetic on screen indices.
package screen_pkg;

  localparam int unsigned SCREEN_W = 4;

  typedef enum logic [1:0] {
    MANUAL,
    AUTO,
    OVR_MANUAL,
    OVR_AUTO
  } state_t;

  // Highest valid screen index for a given screen count.
  function automatic logic [SCREEN_W-1:0] last_screen(input int unsigned num_screens);
    return SCREEN_W'(num_screens - 1);
  endfunction

  // Step forward, wrapping explicitly at the last valid screen (not modulo-16).
  function automatic logic [SCREEN_W-1:0] inc_wrap(input logic [SCREEN_W-1:0] cur,
                                                    input int unsigned         num_screens);
    return (cur == last_screen(num_screens)) ? '0 : cur + SCREEN_W'(1);
  endfunction

  // Step backward, wrapping from 0 to the last valid screen.
  function automatic logic [SCREEN_W-1:0] dec_wrap(input logic [SCREEN_W-1:0] cur,
                                                    input int unsigned         num_screens);
    return (cur == '0) ? last_screen(num_screens) : cur - SCREEN_W'(1);
  endfunction

  // Out-of-range switch requests select the last valid screen.
  function automatic logic [SCREEN_W-1:0] clamp_screen(input logic [SCREEN_W-1:0] req,
                                                        input int unsigned         num_screens);
    return (req > last_screen(num_screens)) ? last_screen(num_screens) : req;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Dwell timer for the slideshow: counts enabled cycles and flags the cycle in
// which the count reaches DWELL_CYCLES-1. The counter restarts on clr, on
// expiry, and is held at 0 while disabled.
module dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 150000000,
  parameter int unsigned CNT_W        = 28
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // Raw terminal-count flag; the owner decides whether a higher-priority event
  // overrides it (and asserts clr in that case).
  assign expire = en && (cnt == LAST_CNT);

  // Dwell count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || !en || expire) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Screen select control for frame_writer: manual next/prev stepping, an
// auto-advance slideshow with a fixed dwell time, and a switch override that
// picks the screen directly. Priority: override > mode > step > dwell expiry.
module screen_sequencer
  import screen_pkg::*;
#(
  parameter int unsigned NUM_SCREENS  = 10,
  parameter int unsigned DWELL_CYCLES = 150000000,
  parameter int unsigned CNT_W        = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                next_pulse,
  input  logic                prev_pulse,
  input  logic                mode_pulse,
  input  logic                sw_override,
  input  logic [SCREEN_W-1:0] sw_screen,
  output logic [SCREEN_W-1:0] screen,
  output logic                auto_mode,
  output logic                override_active,
  output logic                changed
);

  state_t              state;
  state_t              state_next;
  logic [SCREEN_W-1:0] screen_next;
  logic                dwell_en;
  logic                dwell_clr;
  logic                expire;

  // The dwell counter only runs in AUTO; elsewhere it is held at 0.
  assign dwell_en = (state == AUTO);

  dwell_timer #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .CNT_W        (CNT_W)
  ) u_dwell_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (dwell_en),
    .clr    (dwell_clr),
    .expire (expire)
  );

  // Next state and next screen, resolved in priority order.
  always_comb begin
    state_next  = state;
    screen_next = screen;
    dwell_clr   = 1'b0;
    if (sw_override) begin
      // Entering or staying in override; the non-override mode is remembered.
      dwell_clr   = 1'b1;
      screen_next = clamp_screen(sw_screen, NUM_SCREENS);
      state_next  = (state == MANUAL || state == OVR_MANUAL) ? OVR_MANUAL : OVR_AUTO;
    end else if (state == OVR_MANUAL || state == OVR_AUTO) begin
      // Leaving override keeps the last override screen.
      dwell_clr  = 1'b1;
      state_next = (state == OVR_MANUAL) ? MANUAL : AUTO;
    end else begin
      if (mode_pulse) begin
        dwell_clr  = 1'b1;
        state_next = (state == MANUAL) ? AUTO : MANUAL;
      end
      // A step still applies alongside a mode toggle; next+prev cancel out.
      if (next_pulse && !prev_pulse) begin
        dwell_clr   = 1'b1;
        screen_next = inc_wrap(screen, NUM_SCREENS);
      end else if (prev_pulse && !next_pulse) begin
        dwell_clr   = 1'b1;
        screen_next = dec_wrap(screen, NUM_SCREENS);
      end else if (expire && !mode_pulse) begin
        screen_next = inc_wrap(screen, NUM_SCREENS);
      end
    end
  end

  // FSM state, screen register and change strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= MANUAL;
      screen  <= '0;
      changed <= 1'b0;
    end else begin
      state   <= state_next;
      screen  <= screen_next;
      changed <= (screen_next != screen);
    end
  end

  assign auto_mode       = (state == AUTO) || (state == OVR_AUTO);
  assign override_active = (state == OVR_MANUAL) || (state == OVR_AUTO);

endmodule

// File: tb/tb_screen_sequencer.sv
// Bench for screen_sequencer (NUM_SCREENS=4, DWELL_CYCLES=8): directed steps
// followed by random pulses, all compared against a cycle-level reference model.
module tb_screen_sequencer;

  localparam int N  = 4;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       next_pulse, prev_pulse, mode_pulse, sw_override;
  logic [3:0] sw_screen;
  logic [3:0] screen;
  logic       auto_mode, override_active, changed;

  always #5 clk = ~clk;

  screen_sequencer #(
    .NUM_SCREENS  (N),
    .DWELL_CYCLES (DW),
    .CNT_W        (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .next_pulse      (next_pulse),
    .prev_pulse      (prev_pulse),
    .mode_pulse      (mode_pulse),
    .sw_override     (sw_override),
    .sw_screen       (sw_screen),
    .screen          (screen),
    .auto_mode       (auto_mode),
    .override_active (override_active),
    .changed         (changed)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: screen as an integer, modes as flags, dwell as idle-cycle count.
  int m_screen;
  int m_dwell;
  bit m_auto;
  bit m_ovr;
  bit m_changed;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_screen  = 0;
    m_dwell   = 0;
    m_auto    = 0;
    m_ovr     = 0;
    m_changed = 0;
  endtask

  task automatic model_step(input bit nx, input bit pv, input bit md, input bit ov,
                            input int sws);
    int old;
    old = m_screen;
    if (ov) begin
      m_screen = (sws > N - 1) ? N - 1 : sws;
      m_ovr    = 1;
      m_dwell  = 0;
    end else if (m_ovr) begin
      m_ovr   = 0;
      m_dwell = 0;
    end else begin
      if (md) begin
        m_auto  = !m_auto;
        m_dwell = 0;
      end
      if (nx && !pv) begin
        m_screen = (m_screen + 1) % N;
        m_dwell  = 0;
      end else if (pv && !nx) begin
        m_screen = (m_screen + N - 1) % N;
        m_dwell  = 0;
      end else if (!md && m_auto) begin
        if (m_dwell == DW - 1) begin
          m_screen = (m_screen + 1) % N;
          m_dwell  = 0;
        end else begin
          m_dwell++;
        end
      end
    end
    if (!m_auto || m_ovr) m_dwell = 0;
    m_changed = (m_screen != old);
  endtask

  // One clock: drive pulses, advance the model at the edge, check #1 later.
  task automatic cyc(input bit nx = 0, input bit pv = 0, input bit md = 0);
    next_pulse = nx;
    prev_pulse = pv;
    mode_pulse = md;
    @(posedge clk);
    model_step(nx, pv, md, sw_override, int'(sw_screen));
    #1;
    chk("screen", 32'(screen), 32'(m_screen));
    chk("changed", 32'(changed), 32'(m_changed));
    chk("auto_mode", 32'(auto_mode), 32'(m_auto));
    chk("override_active", 32'(override_active), 32'(m_ovr));
    next_pulse = 0;
    prev_pulse = 0;
    mode_pulse = 0;
  endtask

  initial begin
    rst         = 1;
    next_pulse  = 0;
    prev_pulse  = 0;
    mode_pulse  = 0;
    sw_override = 0;
    sw_screen   = 0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset_screen", 32'(screen), 0);
    chk("reset_changed", 32'(changed), 0);
    chk("reset_auto", 32'(auto_mode), 0);
    chk("reset_ovr", 32'(override_active), 0);
    rst = 0;

    // Three spaced next pulses, then a wrapping fourth.
    for (int k = 1; k <= 3; k++) begin
      cyc(1, 0, 0);
      chk("next_step", 32'(screen), 32'(k));
      chk("next_changed", 32'(changed), 1);
      cyc();
      chk("next_changed_drop", 32'(changed), 0);
    end
    cyc(1, 0, 0);
    chk("next_wrap", 32'(screen), 0);

    // prev wraps back; simultaneous next+prev is a no-op.
    cyc(0, 1, 0);
    chk("prev_wrap", 32'(screen), 3);
    cyc(1, 1, 0);
    chk("both_hold", 32'(screen), 3);
    chk("both_nochg", 32'(changed), 0);

    // Auto mode: advance every DW cycles.
    cyc(0, 0, 1);
    chk("mode_auto", 32'(auto_mode), 1);
    repeat (DW - 1) cyc();
    chk("dwell_hold", 32'(screen), 3);
    cyc();
    chk("dwell_adv0", 32'(screen), 0);
    chk("dwell_chg0", 32'(changed), 1);
    repeat (DW) cyc();
    chk("dwell_adv1", 32'(screen), 1);

    // A step mid-dwell restarts the dwell.
    repeat (4) cyc();
    cyc(1, 0, 0);
    chk("mid_next", 32'(screen), 2);
    repeat (DW - 1) cyc();
    chk("restart_hold", 32'(screen), 2);
    cyc();
    chk("restart_adv", 32'(screen), 3);

    // Override with out-of-range request; pulses ignored meanwhile.
    sw_override = 1;
    sw_screen   = 4'd9;
    cyc();
    chk("ovr_clamp", 32'(screen), 3);
    chk("ovr_active", 32'(override_active), 1);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    cyc(0, 1, 0);
    chk("ovr_ignore", 32'(screen), 3);
    chk("ovr_keep_auto", 32'(auto_mode), 1);
    sw_screen = 4'd1;
    cyc();
    chk("ovr_direct", 32'(screen), 1);
    sw_override = 0;
    cyc();
    chk("ovr_release", 32'(override_active), 0);
    chk("ovr_back_auto", 32'(auto_mode), 1);
    repeat (DW - 1) cyc();
    chk("release_hold", 32'(screen), 1);
    cyc();
    chk("release_adv", 32'(screen), 2);

    // Asynchronous reset mid-dwell at screen 2.
    repeat (3) cyc();
    #2;
    rst = 1;
    #1;
    model_reset();
    chk("areset_screen", 32'(screen), 0);
    chk("areset_auto", 32'(auto_mode), 0);
    chk("areset_changed", 32'(changed), 0);
    @(posedge clk);
    #1;
    rst = 0;
    repeat (20) cyc();
    chk("post_reset_idle", 32'(screen), 0);

    // Random phase.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) sw_override = ~sw_override;
      if (sw_override && $urandom_range(0, 3) == 0) sw_screen = 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0,
          $urandom_range(0, 19) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
